// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and default width for the multiply/divide sequencer
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FIX   = 2'd3;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration, add-shift multiply or restoring subtract-shift divide
// Ports: div selects divide; acc is {hi,lo} working pair; opd is multiplicand/divisor; nxt is the stepped pair.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opd,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] sum, cand, diff;
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign cand = acc[2*WIDTH-1:WIDTH-1];
  // diff[WIDTH] is the borrow: set means the partial remainder is below the divisor
  assign diff = cand - {1'b0, opd};
  assign nxt  = div ? {diff[WIDTH] ? cand[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                    : {sum, acc[WIDTH-1:1]};
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative HI/LO multiply/divide sequencer for the multicycle CPU
// Ports: clk, rst_n (async active-low); start/op/rs/rt request; abort cancels;
//   busy stalls the control unit; done = hi_we = lo_we one-cycle pulse; hi_out/lo_out results.
// Option: MDU_EARLY_OUT_EN skips the iteration loop when either operand is zero.
module mdu_sequencer import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  logic [1:0] state, op_q;
  logic [WIDTH-1:0] rs_q, rt_q, opd, ma, mb, q_fix, r_fix, hi_res, lo_res;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [CNT_W-1:0] cnt;
  logic neg_lo, neg_hi, is_div, is_signed, sa, sb, zero, early;
  assign is_div    = !(op_q == OP_MULTU || op_q == OP_MULT);
  assign is_signed = op_q == OP_MULT || op_q == OP_DIV;
  assign sa        = is_signed & rs_q[WIDTH-1];
  assign sb        = is_signed & rt_q[WIDTH-1];
  assign ma        = sa ? -rs_q : rs_q;
  assign mb        = sb ? -rt_q : rt_q;
  assign zero      = rs_q == '0 || rt_q == '0;
`ifdef MDU_EARLY_OUT_EN
  assign early     = zero;
`else
  assign early     = 1'b0;
`endif
  assign prod      = neg_lo ? -acc : acc;
  assign q_fix     = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix     = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  // zero override also covers an early-out multiply whose accumulator never ran
  assign hi_res    = is_div ? (rt_q == '0 ? rs_q : r_fix) : (zero ? '0 : prod[2*WIDTH-1:WIDTH]);
  assign lo_res    = is_div ? (rt_q == '0 ? '1 : q_fix) : (zero ? '0 : prod[WIDTH-1:0]);
  assign busy      = state != S_IDLE || done;
  assign hi_we     = done;
  assign lo_we     = done;
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div (is_div),
    .acc (acc),
    .opd (opd),
    .nxt (acc_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      opd    <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) state <= S_IDLE;
      else begin
        case (state)
          S_IDLE: if (start && !abort) begin
            state <= S_SETUP;
            op_q  <= op;
            rs_q  <= rs;
            rt_q  <= rt;
          end
          S_SETUP: begin
            acc    <= {{WIDTH{1'b0}}, is_div ? ma : mb};
            opd    <= is_div ? mb : ma;
            neg_lo <= sa ^ sb;
            neg_hi <= is_div ? sa : sa ^ sb;
            cnt    <= CNT_W'(WIDTH);
            state  <= early ? S_FIX : S_RUN;
          end
          S_RUN: begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= S_FIX;
          end
          default: begin
            hi_out <= hi_res;
            lo_out <= lo_res;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for the multiply/divide sequencer
module tb_mdu_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] rs = '0, rt = '0;
  logic busy, done, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;
  logic [63:0] sb[$];
  logic [63:0] last_exp = '0;
  int checks = 0, errors = 0;
  mdu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt), .abort(abort),
    .busy(busy), .done(done), .hi_we(hi_we), .lo_we(lo_we), .hi_out(hi_out), .lo_out(lo_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sbv;
    longint p;
    sa = $signed(a);
    sbv = $signed(b);
    if (o == 2'b00) return {32'h0, a} * {32'h0, b};
    if (o == 2'b01) begin
      p = longint'(sa) * longint'(sbv);
      return 64'(p);
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (o == 2'b10) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'(sa % sbv), 32'(sa / sbv)};
  endfunction
  function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    return (a == 0 || b == 0) ? 2 : 34;
`else
    return 34;
`endif
  endfunction
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    @(negedge clk);
    op = o; rs = a; rt = b; start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'h0, busy}, 64'h1);
  endtask
  task automatic finish_op(input string tag, input int lat);
    int k = 0;
    logic [63:0] exp;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    exp = sb.pop_front();
    if (!done) check({tag, "_timeout"}, 64'h0, 64'h1);
    else begin
      check({tag, "_latency"}, 64'(k), 64'(lat));
      check({tag, "_result"}, {hi_out, lo_out}, exp);
      check({tag, "_we_busy"}, {61'h0, hi_we, lo_we, busy}, 64'h7);
      last_exp = exp;
      @(negedge clk);
      check({tag, "_pulse_end"}, {62'h0, done, busy}, 64'h0);
    end
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    issue(o, a, b, exp);
    finish_op(tag, lat_of(a, b));
  endtask
  task automatic quiet(input string tag, input int n);
    int c = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) c++;
    end
    check(tag, 64'(c), 64'h0);
  endtask
  initial begin
    logic [1:0] o;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, hi_we, lo_we, hi_out, lo_out}, 68'h0);
    rst_n = 1'b1;
    run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    run("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run("divu_zero", 2'b10, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
    run("div_zero_neg", 2'b11, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF});
    run("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0});
    run("multu_early", 2'b00, 32'd0, 32'd5, 64'h0);
    run("div_zero_num", 2'b11, 32'd0, 32'hFFFF_FFF0, 64'h0);
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 5) ? 32'($urandom_range(1, 9)) : $urandom;
      run("random", o, a, b, ref_model(o, a, b));
    end
    issue(2'b10, 32'd1000, 32'd7, {32'd6, 32'd142});
    repeat (5) @(negedge clk);
    op = 2'b00; rs = 32'd3; rt = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("start_ignored", 28);
    quiet("no_second_done", 40);
    issue(2'b00, 32'h1234, 32'h5678, 64'h0);
    void'(sb.pop_front());
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {63'h0, busy}, 64'h0);
    quiet("abort_no_done", 40);
    check("abort_hold", {hi_out, lo_out}, last_exp);
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 2'b00; rs = 32'd2; rt = 32'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", {63'h0, busy}, 64'h0);
    quiet("abort_start_no_done", 40);
    issue(2'b01, 32'd11, 32'd13, 64'd143);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {busy, done, hi_out, lo_out}, 66'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run("after_reset", 2'b10, 32'd77, 32'd10, {32'd7, 32'd7});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO computation for the multicycle CPU.
- Accepts a one-cycle start pulse and operands from the control unit, runs a shift-add/shift-subtract loop, and returns a one-cycle done pulse with hi/lo write enables.
- The control unit stalls its EXE/WB sequencing on busy; hi/lo registers latch the results on hi_we/lo_we.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH (hi = upper WIDTH, lo = lower WIDTH).
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse, sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- rs  in  WIDTH  multiplicand / dividend.
- rt  in  WIDTH  multiplier / divisor.
- abort  in  1  cancel the current operation (exception/eret path).
- busy  out  1  operation in flight; control unit holds state while high.
- done  out  1  one-cycle completion pulse.
- hi_we  out  1  HI write enable; equals done.
- lo_we  out  1  LO write enable; equals done.
- hi_out  out  WIDTH  MULT*: product[2W-1:W]; DIV*: remainder.
- lo_out  out  WIDTH  MULT*: product[W-1:0]; DIV*: quotient.

Behaviour:
- Reset (rst_n low, async): state=IDLE, counter=0, busy=0, done=0, hi_we=0, lo_we=0, hi_out=0, lo_out=0, all internal accumulators 0.
- FSM states: IDLE, SETUP, RUN, FIX.
  - IDLE: start=1 and abort=0 at edge E0 -> SETUP; latch op, rs, rt; busy=1 from E0.
  - SETUP (1 cycle): signed ops take magnitudes of rs/rt and record result sign (MULT: sa^sb; DIV: quotient sa^sb, remainder sa). Unsigned ops pass operands through. Counter=WIDTH. -> RUN.
  - RUN (WIDTH cycles): one radix-2 step per cycle, counter decrements; at counter==1 -> FIX.
    - Multiply: add the multiplicand when acc LSB=1, then shift right.
    - Divide: restoring shift-subtract.
  - FIX (1 cycle): apply sign negation, register hi_out/lo_out, and pulse done=hi_we=lo_we=1 -> IDLE.
- Latency: done high in the cycle after edge E0+WIDTH+2 (34 cycles for WIDTH=32). busy stays high through the done cycle and drops after the following edge. hi_out/lo_out hold their value until the next FIX.
- start while busy: ignored, with no queueing.
- abort in any non-IDLE state: -> IDLE at next edge; busy=0, done/we stay 0, hi_out/lo_out unchanged.
- abort and start together in IDLE: abort wins, nothing starts.
- Divide by zero (both signs): lo_out = all ones, hi_out = raw rs. Normal latency, no trap.
- DIV 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0 (wraps, no trap).
- MULT of 0x80000000 * 0x80000000: hi=0x40000000, lo=0.
- Arithmetic is WIDTH+1 bits internally for the divide subtract, and 2*WIDTH for the product accumulator; no truncation before FIX.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
  - Defined: in SETUP, if rt==0 (any op) or rs==0 (any op), skip RUN and go to FIX next edge. Results are as specified above (zero operand -> product 0; DIV* by 0 -> lo all ones, hi=rs; 0 / x -> 0,0). done arrives after edge E0+2.
  - Undefined: every operation takes the full WIDTH+2 latency.

Decomposition:
- Package mdu_pkg: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), state encoding (S_IDLE, S_SETUP, S_RUN, S_FIX), default WIDTH.
- Sub-module mdu_step: purely combinational single-iteration step (mul add-shift / div subtract-shift, selected by op[1]). It is instantiated once; the sequencer owns all registers and the FSM.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 34 cycles hi=0xFFFFFFFE lo=0x00000001; done/hi_we/lo_we one cycle; busy high 34 cycles.
- MULT rs=0xFFFFFFFD(-3) rt=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV rs=-7 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU rs=100 rt=0 -> lo=0xFFFFFFFF hi=100; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
- Start pulse at cycle 5 of a running DIVU -> ignored; only the first result appears; done pulses once.
- abort at RUN cycle 10 -> busy=0 next cycle, no done, hi_out/lo_out keep previous result; abort+start together in IDLE -> stays IDLE.
- rst_n asserted mid-RUN (asynchronous, between edges) -> outputs zero immediately; with MDU_EARLY_OUT_EN, MULTU rs=0 rt=5 -> done after 2 cycles with hi=lo=0.
